// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request bus and register-file write port bundle
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 wen;
  logic [AW-1:0]        wraddr;
  logic [DW-1:0]        wrdata;
  logic [AW-1:0]        hz_addr1;
  logic [AW-1:0]        hz_addr2;
  logic                 hz_hit1;
  logic                 hz_hit2;

  modport master (
    output stall, req_valid, req_addr, req_data, hz_addr1, hz_addr2,
    input  req_ready, wen, wraddr, wrdata, hz_hit1, hz_hit2
  );

  modport slave (
    input  stall, req_valid, req_addr, req_data, hz_addr1, hz_addr2,
    output req_ready, wen, wraddr, wrdata, hz_hit1, hz_hit2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with hazard lookup
// WB_ARB_RR_EN selects round-robin arbitration; fixed priority (lowest index wins) otherwise.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            wen_q, wen_d;
  logic [AW-1:0]   wraddr_q, wraddr_d;
  logic [DW-1:0]   wrdata_q, wrdata_d;
  logic            hit1, hit2;

`ifdef WB_ARB_RR_EN
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  // Scan offsets from rr_ptr; the first valid candidate in rotated order wins.
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    rr_ptr_d = rr_ptr_q;
    if (!bus.stall) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!xfer && bus.req_valid[j] && (((int'(rr_ptr_q) + k) % NREQ) == j)) begin
            xfer     = 1'b1;
            grant[j] = 1'b1;
            sel_addr = bus.req_addr[j*AW +: AW];
            sel_data = bus.req_data[j*DW +: DW];
            rr_ptr_d = PW'((j + 1) % NREQ);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (!bus.stall) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!xfer && bus.req_valid[j]) begin
          xfer     = 1'b1;
          grant[j] = 1'b1;
          sel_addr = bus.req_addr[j*AW +: AW];
          sel_data = bus.req_data[j*DW +: DW];
        end
      end
    end
  end
`endif

  // x0 writes are accepted but never raise wen; address/data still load.
  always_comb begin
    wen_d    = xfer && (sel_addr != '0);
    wraddr_d = xfer ? sel_addr : wraddr_q;
    wrdata_d = xfer ? sel_data : wrdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q    <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      wen_q    <= wen_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end

  // Pending writes are either still requesting or sitting in the output register.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (bus.req_valid[j] && (bus.req_addr[j*AW +: AW] == bus.hz_addr1)) hit1 = 1'b1;
      if (bus.req_valid[j] && (bus.req_addr[j*AW +: AW] == bus.hz_addr2)) hit2 = 1'b1;
    end
    if (wen_q && (wraddr_q == bus.hz_addr1)) hit1 = 1'b1;
    if (wen_q && (wraddr_q == bus.hz_addr2)) hit2 = 1'b1;
    if (bus.hz_addr1 == '0) hit1 = 1'b0;
    if (bus.hz_addr2 == '0) hit2 = 1'b0;
  end

  assign bus.req_ready = grant;
  assign bus.wen       = wen_q;
  assign bus.wraddr    = wraddr_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.hz_hit1   = hit1;
  assign bus.hz_hit2   = hit2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall     = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hz_addr1  = '0;
    bus.hz_addr2  = '0;
  endtask

  int exp_g [4];

  initial begin
`ifdef WB_ARB_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    idle_inputs();
    #2;
    check("rst_wen",    64'(bus.wen),       64'd0);
    check("rst_wraddr", 64'(bus.wraddr),    64'd0);
    check("rst_wrdata", 64'(bus.wrdata),    64'd0);
    check("rst_ready",  64'(bus.req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_wen",    64'(bus.wen),    64'd0);
    check("idle_wrdata", 64'(bus.wrdata), 64'd0);

    // single ALU write
    bus.req_valid = 3'b001;
    bus.req_addr[0*AW +: AW] = 5'd5;
    bus.req_data[0*DW +: DW] = 32'h1234;
    #1;
    check("alu_ready", 64'(bus.req_ready), 64'b001);
    step();
    bus.req_valid = '0;
    check("alu_wen",    64'(bus.wen),    64'd1);
    check("alu_wraddr", 64'(bus.wraddr), 64'd5);
    check("alu_wrdata", 64'(bus.wrdata), 64'h1234);
    step();
    check("alu_wen_off",  64'(bus.wen),    64'd0);
    check("alu_hold_adr", 64'(bus.wraddr), 64'd5);

    // contention from reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW] = AW'(i + 1);
      bus.req_data[i*DW +: DW] = DW'(32'hA0 + i);
    end
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("cont_ready%0d", c), 64'(bus.req_ready), 64'(1 << exp_g[c]));
      step();
      check($sformatf("cont_wen%0d", c),    64'(bus.wen),    64'd1);
      check($sformatf("cont_wraddr%0d", c), 64'(bus.wraddr), 64'(exp_g[c] + 1));
      check($sformatf("cont_wrdata%0d", c), 64'(bus.wrdata), 64'(32'hA0 + exp_g[c]));
    end
    idle_inputs();
    step();
    check("cont_wen_off", 64'(bus.wen), 64'd0);

    // x0 write from LSU
    bus.req_valid = 3'b010;
    bus.req_addr[1*AW +: AW] = 5'd0;
    bus.req_data[1*DW +: DW] = 32'hFFFF_FFFF;
    bus.hz_addr1 = 5'd0;
    #1;
    check("x0_ready", 64'(bus.req_ready), 64'b010);
    check("x0_hz_req", 64'(bus.hz_hit1), 64'd0);
    step();
    bus.req_valid = '0;
    #1;
    check("x0_wen",    64'(bus.wen),     64'd0);
    check("x0_wrdata", 64'(bus.wrdata),  64'hFFFF_FFFF);
    check("x0_hz_reg", 64'(bus.hz_hit1), 64'd0);

    // hazard under stall
    bus.stall = 1'b1;
    bus.req_valid = 3'b100;
    bus.req_addr[2*AW +: AW] = 5'd7;
    bus.req_data[2*DW +: DW] = 32'h77;
    bus.hz_addr1 = 5'd7;
    bus.hz_addr2 = 5'd8;
    #1;
    check("stall_ready", 64'(bus.req_ready), 64'b000);
    check("stall_hit1",  64'(bus.hz_hit1),   64'd1);
    check("stall_hit2",  64'(bus.hz_hit2),   64'd0);
    step();
    check("stall_wen",   64'(bus.wen),       64'd0);
    bus.stall = 1'b0;
    #1;
    check("unstall_ready", 64'(bus.req_ready), 64'b100);
    step();
    bus.req_valid = '0;
    bus.stall = 1'b1;
    #1;
    check("hz_wen",      64'(bus.wen),     64'd1);
    check("hz_wraddr",   64'(bus.wraddr),  64'd7);
    check("hz_reg_hit1", 64'(bus.hz_hit1), 64'd1);
    check("hz_reg_hit2", 64'(bus.hz_hit2), 64'd0);
    step();
    bus.stall = 1'b0;
    check("hz_clear", 64'(bus.hz_hit1), 64'd0);

    // reset during the output cycle of a write
    bus.req_valid = 3'b001;
    bus.req_addr[0*AW +: AW] = 5'd9;
    bus.req_data[0*DW +: DW] = 32'h99;
    step();
    bus.req_valid = '0;
    check("mid_wen_pre", 64'(bus.wen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wen_rst",    64'(bus.wen),    64'd0);
    check("mid_wraddr_rst", 64'(bus.wraddr), 64'd0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 3'b101;
    bus.req_addr[2*AW +: AW] = 5'd3;
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'b001);
    step();
    idle_inputs();
    check("post_rst_wraddr", 64'(bus.wraddr), 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port among NREQ write-back requesters (ALU, LSU, CSR in the RV32 core) using a valid/ready handshake, and registers the winning write onto the wen/wraddr/wrdata port of the register file. It also reports pending-write hazards for two decode-stage read addresses so the issue logic can stall. It sits between the execute/memory write-back sources and the register file.

## Interface
- NREQ, 3: number of requesters, legal range 2..4; index 0 = ALU, 1 = LSU, 2 = CSR
- AW, 5: register address width
- DW, 32: register data width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  when 1, no request is granted this cycle
- req_valid  in  NREQ  request i valid
- req_ready  out  NREQ  grant to request i (combinational)
- req_addr  in  NREQ*AW  destination register, slice i = [i*AW +: AW]
- req_data  in  NREQ*DW  write data, slice i = [i*DW +: DW]
- wen  out  1  register-file write enable (registered)
- wraddr  out  AW  register-file write address (registered)
- wrdata  out  DW  register-file write data (registered)
- hz_addr1  in  AW  first read address to check
- hz_addr2  in  AW  second read address to check
- hz_hit1  out  1  hz_addr1 has a pending write
- hz_hit2  out  1  hz_addr2 has a pending write

## Operation
- At most one request is granted per cycle. A transfer occurs on a cycle where req_valid[i] && req_ready[i].
- req_ready is one-hot or zero. All bits are 0 when stall=1 or when no req_valid is set.
- Grant selection depends on WB_ARB_RR_EN (see Configuration).
- Requesters must hold valid, addr, and data stable until they are granted. The arbiter does not need to handle a requester dropping valid before grant.
- The output register loads on a transfer:
  - wen <= (addr != 0)
  - wraddr <= addr
  - wrdata <= data
- Without a transfer, wen <= 0. wraddr and wrdata hold their values.
- A write to x0 is accepted (ready asserted) but dropped (wen=0). This matches the register file's x0 rule.
- hz_hitN = 1 when hz_addrN != 0 and either:
  - any req_valid[i] with req_addr slice == hz_addrN, or
  - wen=1 and wraddr == hz_addrN.
- hz_hit is combinational and independent of stall.
- Round-robin state rr_ptr (width clog2(NREQ)) holds the current highest-priority index.
  - After a grant to index g: rr_ptr <= (g+1) mod NREQ.
  - With no grant, rr_ptr holds.
  - Wrap-around: a grant to NREQ-1 sets rr_ptr to 0.

## Timing
- Reset values: wen=0, wraddr=0, wrdata=0, rr_ptr=0. req_ready and hz_hit follow their inputs combinationally.
- Latency: a transfer in cycle T appears on wen/wraddr/wrdata in cycle T+1. The register file commits on the edge ending T+1.
- Throughput: one write per cycle, back-to-back.
- Simultaneous valid requests: exactly one is granted. The losers keep valid asserted and are granted in later cycles.
- stall=1 while wen=1: the in-flight write still completes in that cycle. stall only blocks new grants.
- Reset asserted mid-operation: the pending output write is discarded and wen drops to 0 immediately (asynchronous).
- Reset deassertion is assumed synchronised externally.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration. The first valid index scanning rr_ptr, rr_ptr+1, … (mod NREQ) wins.
- WB_ARB_RR_EN undefined: fixed priority, lowest index wins (ALU > LSU > CSR). rr_ptr is not instantiated.

## Test plan
- Reset then idle: rst_n=0 -> wen=0, wraddr=0, wrdata=0, req_ready=0. Release with no valids -> outputs unchanged.
- Single ALU write: req_valid=001, addr0=5, data0=0x1234 -> req_ready=001 in cycle T; in T+1, wen=1, wraddr=5, wrdata=0x1234; in T+2, wen=0.
- Contention with RR enabled: all three valid each cycle (addrs 1/2/3) from reset -> grants 0,1,2,0 on consecutive cycles; wen=1 every cycle after the first. With RR disabled -> index 0 granted every cycle.
- x0 write: LSU valid, addr1=0, data1=0xFFFF_FFFF -> req_ready=010; next cycle wen=0; hz_hit for hz_addr=0 stays 0.
- Hazard and stall: stall=1, CSR valid with addr2=7, hz_addr1=7, hz_addr2=8 -> req_ready=000, hz_hit1=1, hz_hit2=0. Drop stall -> grant; in the following cycle hz_hit1=1 via wen/wraddr=7; one cycle later hz_hit1=0.
- Reset mid-write: transfer in T, rst_n low during T+1 -> wen=0 immediately, rr_ptr=0; after release, the first grant follows reset priority.
